// File: rtl/pu_pkg.sv
// Shared constants and helpers for the pipelined neuron processing unit.
// Optional ReLU on the final result is enabled by defining PU_RELU_EN.
package pu_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;
  localparam int FP_SIGN = 31;

  // Anything with the sign bit set (including -0.0 and negative NaNs) clamps to +0.
  function automatic logic [FP_W-1:0] fp_relu(input logic [FP_W-1:0] v);
    return v[FP_SIGN] ? FP_ZERO : v;
  endfunction
endpackage

// File: rtl/floating_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// denormals flushed to zero; exact cancellation yields +0.
module floating_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              swap, big_s, sub, found, round_up;
  logic [7:0]        eb, es, d;
  logic [22:0]       fb, fs;
  logic [49:0]       sml_full, sml_sh;
  logic [26:0]       mb, ms, diff, norm;
  logic [27:0]       s28;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_s;
  int                lz;

  always_comb begin
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    swap   = (b[30:0] > a[30:0]);
    big_s  = swap ? b[31] : a[31];
    eb     = swap ? b[30:23] : a[30:23];
    fb     = swap ? b[22:0] : a[22:0];
    es     = swap ? a[30:23] : b[30:23];
    fs     = swap ? a[22:0] : b[22:0];
    sub    = a[31] ^ b[31];
    d      = eb - es;
    // Aligned small operand keeps guard/round bits plus a sticky OR of everything shifted out.
    sml_full = {1'b1, fs, 26'd0};
    sml_sh   = (d > 8'd49) ? 50'd0 : (sml_full >> d);
    mb       = {1'b1, fb, 3'd0};
    ms       = {sml_sh[49:24], |sml_sh[23:0]};
    exp_s    = signed'({2'b00, eb});
    s28      = {1'b0, mb} + {1'b0, ms};
    diff     = mb - ms;
    lz       = 0;
    found    = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else         lz = lz + 1;
      end
    end
    if (!sub) begin
      if (s28[27]) begin
        norm  = {s28[27:2], s28[1] | s28[0]};
        exp_s = exp_s + 10'sd1;
      end else begin
        norm  = s28[26:0];
      end
    end else begin
      norm  = diff << lz;
      exp_s = exp_s - signed'(10'(lz));
    end
    round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant_r   = {1'b0, norm[25:3]} + {23'd0, round_up};
    if (mant_r[23]) exp_s = exp_s + 10'sd1;

    if (a_nan || b_nan || (a_inf && b_inf && sub)) result = 32'h7fc00000;
    else if (a_inf)              result = a;
    else if (b_inf)              result = b;
    else if (a_zero && b_zero)   result = {a[31] & b[31], 31'd0};
    else if (a_zero)             result = b;
    else if (b_zero)             result = a;
    else if (!norm[26])          result = 32'd0;
    else if (exp_s >= 10'sd255)  result = {big_s, 8'hff, 23'd0};
    else if (exp_s <= 10'sd0)    result = {big_s, 31'd0};
    else                         result = {big_s, exp_s[7:0], mant_r[22:0]};
  end
endmodule

// File: rtl/floating_multiplier.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even,
// denormal inputs and underflowing results flushed to signed zero.
module floating_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic              sr, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, round_up;
  logic [47:0]       prod;
  logic [46:0]       pn;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_s;

  always_comb begin
    sr     = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    pn     = prod[47] ? prod[46:0] : {prod[45:0], 1'b0};
    exp_s  = signed'({2'b00, a[30:23]}) + signed'({2'b00, b[30:23]}) - 10'sd127
             + (prod[47] ? 10'sd1 : 10'sd0);
    round_up = pn[23] && ((|pn[22:0]) || pn[24]);
    mant_r = {1'b0, pn[46:24]} + {23'd0, round_up};
    if (mant_r[23]) exp_s = exp_s + 10'sd1;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) result = 32'h7fc00000;
    else if (a_inf || b_inf)      result = {sr, 8'hff, 23'd0};
    else if (a_zero || b_zero)    result = {sr, 31'd0};
    else if (exp_s >= 10'sd255)   result = {sr, 8'hff, 23'd0};
    else if (exp_s <= 10'sd0)     result = {sr, 31'd0};
    else                          result = {sr, exp_s[7:0], mant_r[22:0]};
  end
endmodule

// File: rtl/pu_adder_tree.sv
// Registered pairwise floating-point reduction tree (LOG2N levels) with v/last tags
// that advance only when adv is high.
module pu_adder_tree
  import pu_pkg::*;
#(
  parameter int N_INPUTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     in_v,
  input  logic                     in_last,
  input  logic [FP_W*N_INPUTS-1:0] in_data,
  output logic                     out_v,
  output logic                     out_last,
  output logic [FP_W-1:0]          out_data,
  output logic                     out_busy
);
  localparam int LOG2N = $clog2(N_INPUTS);
  localparam int NODES = N_INPUTS - 1;

  // All levels packed into one bus: level k starts at node N - (N >> (k-1)).
  logic [FP_W*NODES-1:0] node_d, node_q;
  logic [LOG2N-1:0]      v_d, v_q, last_d, last_q;

  for (genvar k = 1; k <= LOG2N; k++) begin : g_lvl
    localparam int CNT = N_INPUTS >> k;
    localparam int DST = N_INPUTS - (N_INPUTS >> (k - 1));
    logic [FP_W*2*CNT-1:0] src;
    if (k == 1) begin : g_src_in
      assign src = in_data;
    end else begin : g_src_lvl
      assign src = node_q[FP_W*(N_INPUTS - (N_INPUTS >> (k - 2))) +: FP_W*2*CNT];
    end
    for (genvar j = 0; j < CNT; j++) begin : g_add
      floating_adder u_add (
        .a      (src[FP_W*(2*j)   +: FP_W]),
        .b      (src[FP_W*(2*j+1) +: FP_W]),
        .result (node_d[FP_W*(DST+j) +: FP_W])
      );
    end
  end

  always_comb begin
    v_d    = v_q;
    last_d = last_q;
    if (adv) begin
      v_d[0]    = in_v;
      last_d[0] = in_last;
      for (int k = 1; k < LOG2N; k++) begin
        v_d[k]    = v_q[k-1];
        last_d[k] = last_q[k-1];
      end
    end
  end

  // ---- tree level registers: control ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= '0;
      last_q <= '0;
    end else begin
      v_q    <= v_d;
      last_q <= last_d;
    end
  end

  // ---- tree level registers: data ----
  always_ff @(posedge clk) begin
    if (adv) node_q <= node_d;
  end

  assign out_v    = v_q[LOG2N-1];
  assign out_last = last_q[LOG2N-1];
  assign out_data = node_q[FP_W*(NODES-1) +: FP_W];
  assign out_busy = |v_q;
endmodule

// File: rtl/pu_pipelined.sv
// Pipelined N-lane FP32 dot-product neuron unit: multiply, adder tree, accumulator.
// Define PU_RELU_EN to clamp negative final results to +0.
module pu_pipelined
  import pu_pkg::*;
#(
  parameter int N_INPUTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [FP_W*N_INPUTS-1:0] x_flat,
  input  logic [FP_W*N_INPUTS-1:0] w_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FP_W-1:0]          out_a,
  output logic                     busy
);
  logic                     adv, accept, fire;
  logic [FP_W*N_INPUTS-1:0] prod_d, prod_q;
  logic                     m_v_d, m_v_q, m_last_d, m_last_q;
  logic                     tree_v, tree_last, tree_busy;
  logic [FP_W-1:0]          tree_sum, acc_sum, sum, result_w;
  logic [FP_W-1:0]          acc_d, acc_q, out_a_d, out_a_q;
  logic                     first_d, first_q, out_valid_d, out_valid_q;

  // The whole pipeline moves in lockstep; only a held result can stall it.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_mul
    floating_multiplier u_mul (
      .a      (x_flat[FP_W*i +: FP_W]),
      .b      (w_flat[FP_W*i +: FP_W]),
      .result (prod_d[FP_W*i +: FP_W])
    );
  end

  always_comb begin
    m_v_d    = m_v_q;
    m_last_d = m_last_q;
    if (adv) begin
      m_v_d    = accept;
      m_last_d = accept && in_last;
    end
  end

  // ---- stage M: products ----
  always_ff @(posedge clk) begin
    if (accept) prod_q <= prod_d;
  end

  pu_adder_tree #(.N_INPUTS(N_INPUTS)) u_tree (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .in_v     (m_v_q),
    .in_last  (m_last_q),
    .in_data  (prod_q),
    .out_v    (tree_v),
    .out_last (tree_last),
    .out_data (tree_sum),
    .out_busy (tree_busy)
  );

  floating_adder u_acc (
    .a      (acc_q),
    .b      (tree_sum),
    .result (acc_sum)
  );

  // First beat bypasses the adder so a neuron never depends on 0 + x handling.
  assign sum = first_q ? tree_sum : acc_sum;

`ifdef PU_RELU_EN
  assign result_w = fp_relu(sum);
`else
  assign result_w = sum;
`endif

  always_comb begin
    fire        = adv && tree_v;
    acc_d       = acc_q;
    first_d     = first_q;
    out_a_d     = out_a_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (fire) begin
      if (tree_last) begin
        out_a_d     = result_w;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
        acc_d       = FP_ZERO;
      end else begin
        acc_d       = sum;
        first_d     = 1'b0;
      end
    end
  end

  // ---- stage M control and accumulator stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v_q       <= 1'b0;
      m_last_q    <= 1'b0;
      acc_q       <= FP_ZERO;
      first_q     <= 1'b1;
      out_a_q     <= FP_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      m_v_q       <= m_v_d;
      m_last_q    <= m_last_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_a_q     <= out_a_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign busy      = m_v_q || tree_busy || !first_q;
endmodule

// File: tb/tb_pu_pipelined.sv
// Directed + randomized bench for pu_pipelined using small-integer operands so the
// reference dot products are exact integers converted to FP32 by the bench.
module tb_pu_pipelined;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [32*N-1:0] x_flat, w_flat;
  logic [31:0]     out_a;

  always #5 clk = ~clk;

  pu_pipelined #(.N_INPUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .x_flat    (x_flat),
    .w_flat    (w_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .busy      (busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          acc_int = 0;
  int          acc_cyc = 0;
  int          tries = 0;
  int          xv[N];
  int          wv[N];
  logic [31:0] exp_q[$];
  int          out_cyc[$];
  logic        rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] int2fp(input int v);
    int          a;
    int          msb;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    a   = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if (a[i]) msb = i;
    m = a << (23 - msb);
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  function automatic logic [31:0] model_out(input int s);
`ifdef PU_RELU_EN
    if (s < 0) s = 0;
`endif
    return int2fp(s);
  endfunction

  function automatic int rnd_val();
    int m;
    m = int'($urandom_range(7, 1));
    return ($urandom_range(1, 0) == 1) ? -m : m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Output monitor: every handshake is matched against the reference queue in order.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        check("out_a", out_a, exp_q.pop_front());
        out_cyc.push_back(cyc);
        n_out++;
      end
    end
  end

  task automatic send(input logic last);
    int   dot;
    logic ok;
    dot = 0;
    for (int i = 0; i < N; i++) begin
      x_flat[32*i +: 32] = int2fp(xv[i]);
      w_flat[32*i +: 32] = int2fp(wv[i]);
      dot += xv[i] * wv[i];
    end
    in_valid = 1'b1;
    in_last  = last;
    ok       = 1'b0;
    tries    = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      check("send_accept", {31'd0, ok}, 32'd1);
    end else begin
      acc_cyc = cyc;
      acc_int += dot;
      if (last) begin
        exp_q.push_back(model_out(acc_int));
        acc_int = 0;
      end
    end
  endtask

  task automatic set_all(input int xa, input int wa);
    for (int i = 0; i < N; i++) begin
      xv[i] = xa;
      wv[i] = wa;
    end
  endtask

  task automatic wait_out(input int c0, output int lat);
    int w;
    w   = 0;
    lat = -1;
    while (w < 50) begin
      @(negedge clk);
      w++;
      if (out_valid) begin
        lat = cyc - c0 + 1;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int c_b1;
    int n0;
    int nb;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    x_flat    = '0;
    w_flat    = '0;
    rand_done = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_a", out_a, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: 4 x (1.0 * 2.0) = 8.0
    set_all(1, 2);
    send(1'b1);
    wait_out(acc_cyc, lat);
    check("latency_single", 32'(lat), 32'd4);
    check("single_value", out_a, 32'h41000000);
    drain("drain_single");

    // Two-beat accumulation -> 16.0, one output
    n0 = n_out;
    send(1'b0);
    c_b1 = acc_cyc;
    send(1'b1);
    wait_out(c_b1, lat);
    check("latency_two_beat", 32'(lat), 32'd5);
    check("two_beat_value", out_a, 32'h41800000);
    drain("drain_two_beat");
    check("two_beat_count", 32'(n_out - n0), 32'd1);

    // Backpressure: three neurons queued behind a held output
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        set_all(1, 2);
        send(1'b1);
        set_all(1, 1);
        send(1'b1);
        xv[0] = 1; xv[1] = 1; xv[2] = 0; xv[3] = 0;
        send(1'b1);
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 5; i++) begin
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_hold", out_a, 32'h41000000);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    check("bp_count", 32'(n_out - n0), 32'd3);

    // Reset mid-accumulation discards the partial sum
    n0 = n_out;
    set_all(1, 2);
    send(1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_busy_hold", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    acc_int = 0;
    @(posedge clk);
    #1;
    send(1'b1);
    drain("drain_after_reset");
    check("after_reset_count", 32'(n_out - n0), 32'd1);

    // Negative sum: -4.0, or +0 with ReLU
    set_all(-1, 1);
    send(1'b1);
    drain("drain_negative");

    // Continuous stream of 16 single-beat neurons
    n0 = n_out;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++) begin
        xv[i] = rnd_val();
        wv[i] = rnd_val();
      end
      send(1'b1);
      check("stream_in_ready", 32'(tries), 32'd1);
    end
    drain("drain_stream");
    check("stream_count", 32'(n_out - n0), 32'd16);
    if (out_cyc.size() >= 16)
      check("stream_spacing", 32'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-16]), 32'd15);

    // Random multi-beat neurons under random output backpressure
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          nb = int'($urandom_range(3, 1));
          for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < N; i++) begin
              xv[i] = rnd_val();
              wv[i] = rnd_val();
            end
            send((b == nb - 1) ? 1'b1 : 1'b0);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3, 0) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pu_pipelined.md
Name: pu_pipelined

Overview:
- Parametrised neuron processing unit and next generation of the four-input PU.
- Computes the IEEE-754 single-precision dot product of N_INPUTS x/w pairs through a fully registered pipeline: a multiply stage, a log2(N_INPUTS)-level adder tree and an accumulator.
- Valid/ready handshakes on input and output. Multi-beat accumulation supports neurons wider than N_INPUTS.
- Sits between the layer controller (operand feed) and the activation/result buffer.

Parameters:
- N_INPUTS, 4, number of x/w lanes; power of two, minimum 2.
- LOG2N, $clog2(N_INPUTS), derived localparam, number of adder-tree levels; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat on x_flat/w_flat/in_last is valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_last  in  1  final beat of the current neuron.
- x_flat  in  32*N_INPUTS  inputs; lane i at [32*i+31:32*i].
- w_flat  in  32*N_INPUTS  weights, same packing.
- out_valid  out  1  a result is held on out_a.
- out_ready  in  1  consumer accepts out_a.
- out_a  out  32  accumulated dot product.
- busy  out  1  any beat in flight, or accumulation open (first_q==0).

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits, out_valid and busy go to 0. out_a goes to 32'h0. Accumulator register goes to 0 and first_q to 1. Data registers other than out_a may stay unreset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
- A beat is accepted when in_valid && in_ready.
- When adv = 0, every stage register, including valid and last tags, holds its value.
- Stage M: on an accepted beat, register the N_INPUTS products from floating_multiplier instances, together with v=1 and last.
- When adv = 1 with no accepted beat, v=0 is written (bubble).
- Stages T1..T_LOG2N: level k registers N_INPUTS/2^k sums from floating_adder instances. v and last propagate one stage per advancing cycle.
- Accumulator stage, on an advancing cycle where the tree output is valid:
  - sum = first_q ? tree_out : (acc + tree_out).
  - The first beat bypasses the adder; no reliance on adder zero handling.
  - If last=1: out_a <= sum, out_valid <= 1, first_q <= 1, acc <= 0.
  - If last=0: acc <= sum, first_q <= 0, and out_valid is cleared if it was being consumed.
- Output hold: out_valid stays 1 and out_a stays stable until out_ready=1. On a handshake, out_valid drops unless a new last-sum lands the same cycle, in which case it stays 1 with the new value.
- Latency: LOG2N+2 cycles from acceptance of the last beat to out_valid=1 with no stall. That is 4 for N_INPUTS=4.
- Throughput: one beat per cycle while out_ready=1.
- Beats of consecutive neurons may be back-to-back; in_last separates them.
- in_last=1 on every beat gives a single-beat dot product per beat.
- Reset mid-operation discards all in-flight beats and any partial accumulation. No output is produced for them.
- Numerics:
  - Rounding, denormal, NaN and Inf follow floating_multiplier/floating_adder unchanged.
  - Summation order is fixed: pairwise tree over lanes (0,1),(2,3)..., then beat order into acc.

Optional Feature:
- Macro PU_RELU_EN.
- Defined: the value written to out_a is ReLU(sum), i.e. 32'h0 if sum[31]=1, else sum.
  - Applies to -0.0 and to NaNs with the sign bit set.
  - Applied only at the last-beat write; acc keeps the signed partial sum.
- Undefined: out_a = sum unmodified.
- Latency and handshakes are identical in both builds.

Decomposition:
- Package pu_pkg:
  - FP_W = 32.
  - FP_ZERO = 32'h0.
  - Sign-bit index FP_SIGN = 31.
  - Helper function fp_relu.
- One sub-module, pu_adder_tree: parametrised by N_INPUTS, holds the registered tree levels and v/last tags, and takes adv as a stall input.
- Multipliers and the accumulator stay in pu_pipelined.

Test Plan:
1. Single beat: N_INPUTS=4, all x=3F800000 (1.0), all w=40000000 (2.0), last=1, out_ready=1 -> out_valid at cycle 4 after acceptance, out_a=41000000 (8.0).
2. Two-beat accumulate: beat 1 as in test 1 with last=0, beat 2 identical with last=1, back-to-back -> exactly one output, out_a=41800000 (16.0), one cycle later than test 1 relative to beat 1.
3. Backpressure: stream 3 single-beat neurons with sums 8.0, 4.0 (x=1.0, w=1.0) and 2.0, holding out_ready=0 for 5 cycles -> in_ready=0 while out_valid=1, out_a stays 41000000, then on release 41000000, 40800000, 40000000 in order with no loss or duplication.
4. Reset mid-operation: accept beat 1 (last=0), assert rst low 2 cycles later, release, then send one test-1 beat -> out_a=41000000 (8.0, no stale partial), busy=0 during reset.
5. Negative sum: x=BF800000 (-1.0), w=3F800000 (1.0), last=1 -> out_a=C0800000 (-4.0) without PU_RELU_EN; 00000000 with PU_RELU_EN.
6. Continuous stream: 16 single-beat neurons, in_valid=1, out_ready=1 -> in_ready stays 1, 16 outputs on consecutive cycles, each matching its reference sum.
